// File: rtl/vga_line_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_prefetch_if
// Purpose  : Pixel pop port and VRAM read port of the VGA line prefetcher.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_line_prefetch_if #(
    parameter int PWIDTH = 8,
    parameter int AWIDTH = 19
);
    logic              pix_rd;
    logic [PWIDTH-1:0] pix_data;
    logic              pix_valid;

    logic              vram_rd;
    logic [AWIDTH-1:0] vram_addr;
    logic              vram_busy;
    logic [PWIDTH-1:0] vram_data;
    logic              vram_vld;

    // master: the prefetcher (pixel source towards VGA, read master towards VRAM)
    modport master (
        input  pix_rd,
        output pix_data,
        output pix_valid,
        output vram_rd,
        output vram_addr,
        input  vram_busy,
        input  vram_data,
        input  vram_vld
    );

    modport slave (
        output pix_rd,
        input  pix_data,
        input  pix_valid,
        input  vram_rd,
        input  vram_addr,
        output vram_busy,
        output vram_data,
        output vram_vld
    );
endinterface
`default_nettype wire

// File: rtl/vga_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_prefetch
// Purpose  : Prefetches a frame's pixels from VRAM into a small FWFT buffer
//            and hands them to the VGA timing logic, flagging underflow.
// Revision : 1.0 - initial release
// ============================================================================
module vga_line_prefetch #(
    parameter int PWIDTH  = 8,
    parameter int AWIDTH  = 19,
    parameter int HACTIVE = 640,
    parameter int VACTIVE = 480,
    parameter int DEPTH   = 16
) (
    input  logic                     clk_vga,
    input  logic                     rst_vga_n,
    input  logic                     enable,
    input  logic [AWIDTH-1:0]        frame_base,
    input  logic                     frame_start,
    vga_line_prefetch_if.master      bus,
    output logic                     underflow,
    output logic                     err_sticky,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_NPIX  = HACTIVE * VACTIVE;
    localparam int c_IDX_W = (c_NPIX > 1) ? $clog2(c_NPIX) : 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_NPIX - 1);
    localparam logic [c_LVL_W:0]   c_CREDIT   = (c_LVL_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_RUN      = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PWIDTH-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic [c_LVL_W-1:0] r_outstanding;
    logic [c_IDX_W-1:0] r_fetch_idx;
    logic [c_IDX_W-1:0] r_cons_idx;
    logic [AWIDTH-1:0]  r_base;
    logic               r_err_sticky;

    logic w_fetching;
    logic w_credit;
    logic w_vram_rd;
    logic w_empty;
    logic w_pix_valid;
    logic w_pop;
    logic w_rsp;
    logic w_wr;
    logic w_underflow;
    logic w_restart;

    // ------------------------------------------------------------------------
    // Request / response qualification
    // ------------------------------------------------------------------------
    assign w_fetching  = (r_state == ST_PREFETCH) || (r_state == ST_RUN);
    // Level plus in-flight reads bounds the buffer, so it can never overflow.
    assign w_credit    = ({1'b0, r_level} + {1'b0, r_outstanding}) < c_CREDIT;
    assign w_vram_rd   = w_fetching && !bus.vram_busy && w_credit;
    assign w_empty     = (r_level == '0);
    assign w_pix_valid = (r_state == ST_RUN) && !w_empty;
    assign w_pop       = w_pix_valid && bus.pix_rd;
    assign w_rsp       = bus.vram_vld && (r_outstanding != '0);
    assign w_wr        = w_rsp && w_fetching;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_vga) begin
        if (!rst_vga_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state, error pulse and restart strobe
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_underflow = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_PREFETCH;
                    w_restart   = 1'b1;
                end
            end
            ST_PREFETCH: begin
                if (!enable) begin
                    w_state_nxt = ST_FLUSH;
                end else if (frame_start) begin
                    if (!w_empty) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_underflow = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_nxt = ST_FLUSH;
                end else if ((bus.pix_rd && w_empty) ||
                             (frame_start && (r_cons_idx != '0))) begin
                    w_underflow = 1'b1;
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Leave only once every in-flight read has drained.
                if (r_outstanding == '0) begin
                    w_restart   = 1'b1;
                    w_state_nxt = enable ? ST_PREFETCH : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters, pointers, frame indices and error flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_vga) begin
        if (!rst_vga_n) begin
            r_outstanding <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_fetch_idx   <= '0;
            r_cons_idx    <= '0;
            r_base        <= '0;
            r_err_sticky  <= 1'b0;
        end else begin
            case ({w_vram_rd, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + c_LVL_ONE;
                2'b01:   r_outstanding <= r_outstanding - c_LVL_ONE;
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_restart) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_level     <= '0;
                r_fetch_idx <= '0;
                r_cons_idx  <= '0;
                r_base      <= frame_base;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                    r_cons_idx <= (r_cons_idx == c_IDX_LAST) ? '0 : r_cons_idx + c_IDX_ONE;
                end
                case ({w_wr, w_pop})
                    2'b10:   r_level <= r_level + c_LVL_ONE;
                    2'b01:   r_level <= r_level - c_LVL_ONE;
                    default: r_level <= r_level;
                endcase
                // The first request of the next frame uses a freshly sampled base.
                if (w_vram_rd) begin
                    if (r_fetch_idx == c_IDX_LAST) begin
                        r_fetch_idx <= '0;
                        r_base      <= frame_base;
                    end else begin
                        r_fetch_idx <= r_fetch_idx + c_IDX_ONE;
                    end
                end
            end

            if (w_underflow) begin
                r_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pixel storage (data path only, no reset needed)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_vga) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.vram_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.vram_rd   = w_vram_rd;
    assign bus.vram_addr = r_base + AWIDTH'(r_fetch_idx);
    assign bus.pix_valid = w_pix_valid;
    assign bus.pix_data  = w_pix_valid ? r_mem[r_rd_ptr] : '0;
    assign underflow     = w_underflow;
    assign err_sticky    = r_err_sticky;
    assign level         = r_level;

endmodule
`default_nettype wire

// File: doc/vga_line_prefetch.md
VGA_LINE_PREFETCH -- requirements
Module: vga_line_prefetch

Interface
REQ-001 Parameter PWIDTH, 8, pixel width in bits.
REQ-002 Parameter AWIDTH, 19, VRAM address width.
REQ-003 Parameter HACTIVE, 640, active pixels per line.
REQ-004 Parameter VACTIVE, 480, active lines per frame.
REQ-005 Parameter DEPTH, 16, buffer entries; power of two, >= 4.
REQ-006 Port clk_vga  in  1  single clock for VGA and VRAM sides.
REQ-007 Port rst_vga_n  in  1  reset; synchronous, active-low.
REQ-008 Port enable  in  1  level; 1 = fetch and deliver pixels.
REQ-009 Port frame_base  in  AWIDTH  VRAM address of pixel (0,0); sampled per frame.
REQ-010 Port frame_start  in  1  one-cycle pulse, the cycle before the first active pixel of a frame.
REQ-011 Port pix_rd  in  1  VGA pops one pixel.
REQ-012 Port pix_data  out  PWIDTH  head-of-buffer pixel (first-word-fall-through).
REQ-013 Port pix_valid  out  1  pix_data valid and poppable.
REQ-014 Port vram_rd  out  1  read request, issued in the cycle it is high.
REQ-015 Port vram_addr  out  AWIDTH  read address, valid with vram_rd.
REQ-016 Port vram_busy  in  1  VRAM cannot accept a request this cycle.
REQ-017 Port vram_data  in  PWIDTH  read data.
REQ-018 Port vram_vld  in  1  vram_data valid; returns in request order.
REQ-019 Port underflow  out  1  one-cycle error pulse.
REQ-020 Port err_sticky  out  1  set by any underflow/misalignment; cleared by err_clr.
REQ-021 Port err_clr  in  1  clears err_sticky; set wins when simultaneous.
REQ-022 Port level  out  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-023 States IDLE, PREFETCH, RUN, FLUSH; exactly one active.
REQ-024 IDLE: no requests; enable=1 -> PREFETCH with fetch index 0, frame_base latched.
REQ-025 PREFETCH: fetching; pix_valid=0; pix_rd ignored; frame_start with level>=1 -> RUN; frame_start with level=0 -> stays PREFETCH, underflow pulse, err_sticky set.
REQ-026 RUN: pix_valid = buffer non-empty; pop when pix_rd & pix_valid.
REQ-027 RUN underflow: pix_rd while empty -> underflow pulse same cycle, err_sticky set next cycle, next state FLUSH.
REQ-028 RUN misalignment: frame_start while consumed index != 0 -> same handling as REQ-027.
REQ-029 FLUSH: no requests; returning vram_vld data discarded; when outstanding=0, buffer cleared, fetch index 0, frame_base latched, -> PREFETCH (enable=1) or IDLE (enable=0).
REQ-030 enable=0 in PREFETCH or RUN -> FLUSH next cycle; no error flagged.
REQ-031 vram_rd = ~vram_busy & (state PREFETCH or RUN) & (level + outstanding < DEPTH).
REQ-032 outstanding counter: +1 on vram_rd, -1 on vram_vld; both same cycle -> unchanged.
REQ-033 vram_addr = latched base + fetch index, modulo 2^AWIDTH; fetch index increments per vram_rd, wraps HACTIVE*VACTIVE-1 -> 0.
REQ-034 On fetch index wrap, frame_base is re-latched for the next frame's first request.
REQ-035 Consumed index increments per pop, wraps HACTIVE*VACTIVE-1 -> 0.
REQ-036 vram_vld in PREFETCH/RUN writes buffer; write and pop in same cycle legal at any level, level unchanged.
REQ-037 Buffer never overflows (guaranteed by REQ-031); vram_vld with outstanding=0 ignored.
REQ-038 pix_data when pix_valid=0 is 0.

Reset
REQ-039 rst_vga_n=0 at a clock edge: state IDLE, level 0, outstanding 0, indices 0, err_sticky 0; outputs vram_rd, pix_valid, underflow 0; pix_data 0; vram_addr 0.
REQ-040 Reset mid-operation discards in-flight data; vram_vld in the first cycle after reset is ignored.

Verification
REQ-041 HACTIVE=4, VACTIVE=2, DEPTH=4, frame_base=0x100, busy=0, 2-cycle latency; enable -> addresses 0x100..0x103 issued, then stall until pops; no request exceeds DEPTH credit.
REQ-042 Same setup, RUN, pix_rd each cycle for 8 pixels -> pix_data = mem[0x100..0x107] in order; 9th request uses newly latched frame_base=0x200.
REQ-043 RUN, hold vram_busy=1 for 10 cycles with pix_rd=1 -> underflow pulse once, err_sticky=1, FLUSH waits outstanding 0, returns to PREFETCH, next address = frame_base.
REQ-044 frame_start after 3 of 8 pixels consumed -> underflow pulse, FLUSH, resync; err_clr then clears err_sticky.
REQ-045 Reset asserted with 2 requests outstanding -> all outputs at reset values next cycle; late vram_vld does not change level.
REQ-046 Simultaneous vram_vld and pop at level=DEPTH-1 -> level stays DEPTH-1, data order preserved.
